// File: rtl/svm_pkg.sv
// Shared constants for the SVM decision datapath: FSM encoding, Q8.8 word geometry, sizing helper.
// No logic of its own; imported by svm_mac and svm_decision_acc.
package svm_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_BIAS  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int FRAC_BITS = 8;
    localparam int Q88_W     = 2 * FRAC_BITS;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/svm_mac.sv
// Registered signed x unsigned multiply-accumulate with synchronous clear and enable.
// Latency 1 cycle from operands to acc; no backpressure, en gates the update.
module svm_mac
    import svm_pkg::*;
#(
    parameter int W     = Q88_W,
    parameter int ACC_W = 40
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic [ACC_W-1:0] acc
);

    localparam int PROD_W = 2 * W + 1;

    logic signed [PROD_W-1:0] prod;
    logic        [ACC_W-1:0]  prod_ext;

    // b is unsigned: a zero MSB keeps the signed multiply exact.
    assign prod     = $signed(a) * $signed({1'b0, b});
    assign prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + prod_ext;
        end
    end

endmodule

// File: rtl/svm_decision_acc.sv
// SVM decision stage: sum of alpha*kernel over NUM_OF_SV samples plus bias, giving a Q16.16 score and class.
// Latency: dec_valid two cycles after the last accepted sample; decision held until dec_ready.
module svm_decision_acc
    import svm_pkg::*;
#(
    parameter int XLEN_PIXEL = 8,
    parameter int NUM_OF_SV  = 10,
    parameter int ACC_W      = 40,
    parameter int CNT_W      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    k_valid,
    input  logic [2*XLEN_PIXEL-1:0] k_data,
    input  logic [2*XLEN_PIXEL-1:0] alpha,
    input  logic [2*XLEN_PIXEL-1:0] bias,
    output logic                    k_ready,
    output logic                    dec_valid,
    input  logic                    dec_ready,
    output logic [ACC_W-1:0]        dec_score,
    output logic                    dec_class,
    output logic                    busy
);

    localparam int             W        = 2 * XLEN_PIXEL;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_OF_SV - 1);
    localparam logic [W-1:0]   ONE_Q88  = W'(1 << FRAC_BITS);

    if (NUM_OF_SV < 1) begin : g_chk_nsv
        $error("NUM_OF_SV must be at least 1");
    end
    if (ACC_W < 4 * XLEN_PIXEL + 2 + clog2(NUM_OF_SV)) begin : g_chk_acc
        $error("ACC_W too narrow for NUM_OF_SV products");
    end
    if ((1 << CNT_W) <= NUM_OF_SV) begin : g_chk_cnt
        $error("CNT_W too narrow for NUM_OF_SV");
    end

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] score_hold;
    logic             accept;
    logic             mac_clr;
    logic             mac_en;
    logic [W-1:0]     mac_a;
    logic [W-1:0]     mac_b;

    assign k_ready = (state == ST_ACCUM);
    assign accept  = k_valid && k_ready;
    assign mac_clr = (state == ST_IDLE) && start;
    assign mac_en  = accept || (state == ST_BIAS);

    // Bias reuses the multiplier: bias * 1.0 in Q8.8 is exactly bias <<< FRAC_BITS.
    assign mac_a = (state == ST_BIAS) ? bias    : alpha;
    assign mac_b = (state == ST_BIAS) ? ONE_Q88 : k_data;

    svm_mac #(
        .W     (W),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk (clk),
        .rst (rst),
        .clr (mac_clr),
        .en  (mac_en),
        .a   (mac_a),
        .b   (mac_b),
        .acc (acc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            score_hold <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        cnt   <= '0;
                        state <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (accept) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST_CNT) state <= ST_BIAS;
                    end
                end
                ST_BIAS: state <= ST_DONE;
                default: begin
                    score_hold <= acc;
                    if (dec_ready) state <= ST_IDLE;
                end
            endcase
        end
    end

    // The accumulator is cleared by the next start, so the last score is kept separately for IDLE.
    assign dec_valid = (state == ST_DONE);
    assign dec_score = dec_valid ? acc : score_hold;
    assign dec_class = dec_valid & ~acc[ACC_W-1];
    assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_svm_decision_acc.sv
// Directed bench for svm_decision_acc: hand-computed Q16.16 scores, handshake hold, reset mid-decision.
module tb_svm_decision_acc;

    localparam int NSV = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        k_valid;
    logic [15:0] k_data;
    logic [15:0] alpha;
    logic [15:0] bias;
    logic        k_ready;
    logic        dec_valid;
    logic        dec_ready;
    logic [39:0] dec_score;
    logic        dec_class;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    svm_decision_acc #(
        .XLEN_PIXEL (8),
        .NUM_OF_SV  (NSV),
        .ACC_W      (40),
        .CNT_W      (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .k_valid   (k_valid),
        .k_data    (k_data),
        .alpha     (alpha),
        .bias      (bias),
        .k_ready   (k_ready),
        .dec_valid (dec_valid),
        .dec_ready (dec_ready),
        .dec_score (dec_score),
        .dec_class (dec_class),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full decision: start, NSV samples (optional random bubbles and a stray start),
    // BIAS cycle, DONE held for `hold` cycles, then handshake with a coincident start.
    task automatic run(input string tag, input logic [15:0] a, input logic [15:0] k,
                       input logic [15:0] b, input bit gaps, input int hold,
                       input bit start_mid, input logic [39:0] exp_score, input logic exp_class);
        int g;
        bias  = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, " busy_after_start"}, 64'(busy), 64'd1);
        for (int i = 0; i < NSV; i++) begin
            if (gaps) begin
                g = $urandom_range(0, 2);
                k_valid = 1'b0;
                repeat (g) begin
                    tick();
                    check({tag, " k_ready_bubble"}, 64'(k_ready), 64'd1);
                    check({tag, " dec_valid_bubble"}, 64'(dec_valid), 64'd0);
                end
            end
            if (start_mid && i == 5) start = 1'b1;
            k_valid = 1'b1;
            alpha   = a;
            k_data  = k;
            check({tag, " k_ready_accum"}, 64'(k_ready), 64'd1);
            tick();
            start = 1'b0;
        end
        k_valid = 1'b0;
        check({tag, " bias_dec_valid"}, 64'(dec_valid), 64'd0);
        check({tag, " bias_k_ready"}, 64'(k_ready), 64'd0);
        check({tag, " bias_busy"}, 64'(busy), 64'd1);
        tick();
        check({tag, " done_dec_valid"}, 64'(dec_valid), 64'd1);
        check({tag, " done_score"}, 64'(dec_score), 64'(exp_score));
        check({tag, " done_class"}, 64'(dec_class), 64'(exp_class));
        check({tag, " done_k_ready"}, 64'(k_ready), 64'd0);
        for (int h = 0; h < hold; h++) begin
            k_valid = 1'b1;
            tick();
            check({tag, " hold_dec_valid"}, 64'(dec_valid), 64'd1);
            check({tag, " hold_score"}, 64'(dec_score), 64'(exp_score));
            check({tag, " hold_class"}, 64'(dec_class), 64'(exp_class));
            check({tag, " hold_k_ready"}, 64'(k_ready), 64'd0);
        end
        k_valid   = 1'b0;
        dec_ready = 1'b1;
        start     = 1'b1;
        tick();
        dec_ready = 1'b0;
        start     = 1'b0;
        check({tag, " post_dec_valid"}, 64'(dec_valid), 64'd0);
        check({tag, " post_busy"}, 64'(busy), 64'd0);
        check({tag, " post_score_held"}, 64'(dec_score), 64'(exp_score));
        check({tag, " post_k_ready"}, 64'(k_ready), 64'd0);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        k_valid   = 1'b0;
        k_data    = '0;
        alpha     = '0;
        bias      = '0;
        dec_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("reset busy", 64'(busy), 64'd0);
        check("reset k_ready", 64'(k_ready), 64'd0);
        check("reset dec_valid", 64'(dec_valid), 64'd0);
        check("reset dec_score", 64'(dec_score), 64'd0);
        check("reset dec_class", 64'(dec_class), 64'd0);

        // k_valid in IDLE must be ignored
        k_valid = 1'b1;
        alpha   = 16'h7FFF;
        k_data  = 16'hFFFF;
        tick();
        k_valid = 1'b0;
        check("idle ignores k_valid", 64'(busy), 64'd0);

        // 10 x (1.0 * 0.5) - 4.0 = +1.0
        run("t1_pos", 16'h0100, 16'h0080, 16'hFC00, 1'b0, 0, 1'b0, 40'h00_0001_0000, 1'b1);
        // 10 x (-1.0 * 1.0) + 2.0 = -8.0
        run("t2_neg", 16'hFF00, 16'h0100, 16'h0200, 1'b0, 0, 1'b0, 40'hFF_FFF8_0000, 1'b0);
        // 10 x 1.0 - 10.0 = 0, class 1
        run("t3_zero", 16'h0100, 16'h0100, 16'hF600, 1'b0, 0, 1'b0, 40'h00_0000_0000, 1'b1);
        // 10 x 32767*65535 + (32767 << 8)
        run("t4_ext", 16'h7FFF, 16'hFFFF, 16'h7FFF, 1'b0, 0, 1'b0, 40'h05_0070_FF0A, 1'b1);
        // bubbles and a stalled consumer
        run("t5_gaps", 16'h0100, 16'h0080, 16'hFC00, 1'b1, 5, 1'b0, 40'h00_0001_0000, 1'b1);

        // reset after four accepted extreme samples
        bias  = 16'h7FFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            k_valid = 1'b1;
            alpha   = 16'h7FFF;
            k_data  = 16'hFFFF;
            tick();
        end
        rst = 1'b1;
        tick();
        rst     = 1'b0;
        k_valid = 1'b0;
        check("midrst busy", 64'(busy), 64'd0);
        check("midrst k_ready", 64'(k_ready), 64'd0);
        check("midrst dec_valid", 64'(dec_valid), 64'd0);
        check("midrst dec_score", 64'(dec_score), 64'd0);
        check("midrst dec_class", 64'(dec_class), 64'd0);
        run("t6_after_rst", 16'h0100, 16'h0080, 16'hFC00, 1'b0, 1, 1'b1, 40'h00_0001_0000, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/svm_decision_acc.md
Name: svm_decision_acc

Overview:
- Downstream stage of the HWF kernel unit: consumes one 16-bit unsigned Q8.8 kernel value per support vector and weights it by a signed Q8.8 coefficient (alpha_i*y_i).
- Accumulates the weighted values over NUM_OF_SV samples, adds the signed Q8.8 bias, and emits a signed Q16.16 decision score plus the class bit.
- Sits between the kernel unit and the cascade-stage controller, which reads the decision through a valid/ready handshake.

Parameters:
- XLEN_PIXEL, 8, pixel width; kernel, coefficient and bias words are 2*XLEN_PIXEL bits, Q8.8.
- NUM_OF_SV, 10, number of kernel samples accumulated per decision (>=1).
- ACC_W, 40, accumulator/score width, Q(ACC_W-16).16; must be >= 4*XLEN_PIXEL+2+clog2(NUM_OF_SV).
- CNT_W, 4, sample counter width; must satisfy 2**CNT_W > NUM_OF_SV.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a new decision; honoured only in IDLE.
- k_valid  in  1  kernel sample valid.
- k_data  in  2*XLEN_PIXEL  kernel value, unsigned Q8.8.
- alpha  in  2*XLEN_PIXEL  coefficient for this sample, signed Q8.8; sampled together with k_data.
- bias  in  2*XLEN_PIXEL  signed Q8.8 bias; sampled in the BIAS state.
- k_ready  out  1  block accepts a sample this cycle.
- dec_valid  out  1  decision available.
- dec_ready  in  1  consumer accepts the decision.
- dec_score  out  ACC_W  signed Q(ACC_W-16).16 score.
- dec_class  out  1  1 if dec_score >= 0, else 0.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (synchronous, rst=1 at the clock edge): state IDLE; accumulator, counter and dec_score are 0; k_ready, dec_valid, dec_class and busy are 0. rst wins over every other input, including mid-ACCUM, BIAS or DONE; any partial sum is discarded.
- IDLE: k_ready=0 and k_valid is ignored. When start=1: clear the accumulator and counter, then go to ACCUM.
- ACCUM:
  - k_ready=1. On k_valid&&k_ready, add signed(alpha)*{1'b0,k_data} to the accumulator. The product is 33-bit signed Q16.16, sign-extended to ACC_W. Increment the counter.
  - When a sample is accepted with counter==NUM_OF_SV-1, go to BIAS.
  - Cycles with k_valid=0 are bubbles: no change.
- BIAS: k_ready=0. In one cycle, set acc <= acc + (sign-extended bias <<< 8), then go to DONE.
- DONE:
  - dec_valid=1; dec_score=acc; dec_class=~acc[ACC_W-1], so a score of 0 gives class 1.
  - Outputs are held stable while dec_ready=0.
  - On dec_valid&&dec_ready, go to IDLE; dec_valid drops next cycle and dec_score holds its last value.
- start outside IDLE is ignored, including start coincident with the dec_ready handshake; the controller re-asserts start in IDLE.
- Latency: last sample accepted at edge N → BIAS during cycle N+1 → dec_valid high from cycle N+2. Best-case start-to-dec_valid is NUM_OF_SV+2 cycles.
- No saturation. ACC_W sizing guarantees no overflow for all input values.

Decomposition:
- Shared package svm_pkg:
  - state encoding IDLE/ACCUM/BIAS/DONE (2-bit);
  - FRAC_BITS=8;
  - Q8.8 word-width constant;
  - clog2 helper for ACC_W/CNT_W checks.
- One sub-module, svm_mac: registered signed×unsigned multiply-add with clear and enable. It is reused by later cascade stages. The FSM and the handshake stay in svm_decision_acc.

Test Plan:
- All alpha=0x0100, k_data=0x0080, bias=0xFC00 (NUM_OF_SV=10) → dec_score=0x00_0001_0000, dec_class=1, dec_valid in cycle N+2.
- All alpha=0xFF00, k_data=0x0100, bias=0x0200 → dec_score=0xFF_FFF8_0000 (-8.0), dec_class=0.
- alpha=0x0100, k_data=0x0100, bias=0xF600 → dec_score=0, dec_class=1 (zero boundary).
- Extremes: alpha=0x7FFF, k_data=0xFFFF ×10, bias=0x7FFF → dec_score=0x05_0070_FF0A, no sign flip.
- Random k_valid gaps plus dec_ready low for 5 cycles, using the first test's data → same score; dec_valid and dec_score held stable; k_ready=0 outside ACCUM.
- rst for 1 cycle after 4 accepted samples, then start with the first test's data → result 0x00_0001_0000, no residue; start during ACCUM has no effect.
